// File: rtl/mp64_ifetch_buf_if.sv
// I-cache fetch port of the instruction fetch buffer.
// The buffer owns the master side: it issues addresses and receives hit data.
interface mp64_ifetch_buf_if;
  logic [63:0] fetch_addr;
  logic        fetch_valid;
  logic [63:0] fetch_data;
  logic        fetch_hit;

  modport master (
    output fetch_addr,
    output fetch_valid,
    input  fetch_data,
    input  fetch_hit
  );

  modport slave (
    input  fetch_addr,
    input  fetch_valid,
    output fetch_data,
    output fetch_hit
  );
endinterface

// File: rtl/mp64_ifetch_buf.sv
// 16-byte instruction fetch queue between the I-cache and the decoder.
// Define MP64_IFB_STATS_EN to build the fetch/stall statistics counters.
module mp64_ifetch_buf #(
  parameter int QDEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mp64_ifetch_buf_if.master     ic,
  input  logic                  fetch_en,
  input  logic                  redirect,
  input  logic [63:0]           redirect_pc,
  output logic [63:0]           out_bytes,
  output logic [4:0]            out_count,
  output logic [63:0]           out_pc,
  input  logic                  consume,
  input  logic [3:0]            consume_len,
  output logic [63:0]           stat_fetches,
  output logic [63:0]           stat_stalls
);

  logic [7:0]  qmem_q [QDEPTH];
  logic [7:0]  qmem_d [QDEPTH];
  logic [3:0]  head_q, head_d;
  logic [3:0]  tail_q, tail_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] out_pc_q, out_pc_d;

  logic        fetch_valid;
  logic        accept;
  logic        consume_ok;
  logic [2:0]  offset;
  logic [4:0]  app_n;
  logic [63:0] line_shift;

  // Only fetch when a whole line is guaranteed to fit behind the queued bytes.
  always_comb begin
    fetch_valid = fetch_en & ~redirect & ~rst & (count_q <= 5'd8);
    accept      = fetch_valid & ic.fetch_hit;
    offset      = fetch_pc_q[2:0];
    app_n       = 5'd8 - {2'b00, offset};
    line_shift  = ic.fetch_data >> {offset, 3'b000};
    consume_ok  = consume && (consume_len != 4'd0) && (consume_len <= 4'd8) &&
                  ({1'b0, consume_len} <= count_q);
  end

  assign ic.fetch_valid = fetch_valid;
  assign ic.fetch_addr  = fetch_pc_q;

  always_comb begin
    qmem_d     = qmem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    out_pc_d   = out_pc_q;
    if (redirect) begin
      head_d     = 4'd0;
      tail_d     = 4'd0;
      count_d    = 5'd0;
      fetch_pc_d = redirect_pc;
      out_pc_d   = redirect_pc;
    end else begin
      if (accept) begin
        for (int i = 0; i < 8; i++) begin
          if (5'(i) < app_n) begin
            qmem_d[tail_q + 4'(i)] = line_shift[8*i +: 8];
          end
        end
        tail_d     = tail_q + app_n[3:0];
        fetch_pc_d = {fetch_pc_q[63:3] + 61'd1, 3'b000};
      end
      if (consume_ok) begin
        head_d   = head_q + consume_len;
        out_pc_d = out_pc_q + {60'd0, consume_len};
      end
      count_d = count_q + (accept ? app_n : 5'd0)
                        - (consume_ok ? {1'b0, consume_len} : 5'd0);
    end
  end

  // Queue storage needs no reset: out_bytes masks everything beyond count.
  always_ff @(posedge clk) begin
    qmem_q <= qmem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= 4'd0;
      tail_q     <= 4'd0;
      count_q    <= 5'd0;
      fetch_pc_q <= 64'd0;
      out_pc_q   <= 64'd0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
    end
  end

  always_comb begin
    out_bytes = '0;
    for (int i = 0; i < 8; i++) begin
      out_bytes[8*i +: 8] = (5'(i) < count_q) ? qmem_q[head_q + 4'(i)] : 8'h00;
    end
  end

  assign out_count = count_q;
  assign out_pc    = out_pc_q;

`ifdef MP64_IFB_STATS_EN
  logic [63:0] stat_fetches_q, stat_fetches_d;
  logic [63:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_fetches_d = stat_fetches_q + {63'd0, accept};
    stat_stalls_d  = stat_stalls_q + {63'd0, fetch_valid & ~ic.fetch_hit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetches_q <= 64'd0;
      stat_stalls_q  <= 64'd0;
    end else begin
      stat_fetches_q <= stat_fetches_d;
      stat_stalls_q  <= stat_stalls_d;
    end
  end

  assign stat_fetches = stat_fetches_q;
  assign stat_stalls  = stat_stalls_q;
`else
  assign stat_fetches = 64'd0;
  assign stat_stalls  = 64'd0;
`endif

endmodule

// File: doc/mp64_ifetch_buf.md
MP64_IFETCH_BUF -- requirements
Module: mp64_ifetch_buf

Interface
REQ-001 SHALL have parameter QDEPTH, default 16, meaning byte-queue capacity; only 16 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port fetch_en  input  1  CPU permits fetching; 0 holds fetch_valid low, queue retained.
REQ-005 SHALL have port redirect  input  1  flush queue and restart fetch at redirect_pc.
REQ-006 SHALL have port redirect_pc  input  64  new fetch byte address.
REQ-007 SHALL have port fetch_addr  output  64  byte address to I-cache, equals fetch_pc.
REQ-008 SHALL have port fetch_valid  output  1  fetch request to I-cache.
REQ-009 SHALL have port fetch_data  input  64  8 bytes at fetch_addr[63:3]*8, little-endian.
REQ-010 SHALL have port fetch_hit  input  1  fetch_data valid this cycle.
REQ-011 SHALL have port out_bytes  output  64  next 8 queued bytes; byte i at bits [8i+7:8i].
REQ-012 SHALL have port out_count  output  5  queued bytes available, 0..16.
REQ-013 SHALL have port out_pc  output  64  byte address of out_bytes byte 0.
REQ-014 SHALL have port consume  input  1  decoder retires consume_len bytes this cycle.
REQ-015 SHALL have port consume_len  input  4  bytes retired, 1..8.
REQ-016 SHALL have ports stat_fetches, stat_stalls  output  64 each  accepted fetches; cycles with fetch_valid=1 and fetch_hit=0.

Function
REQ-017 SHALL hold a 16-byte circular queue with 4-bit head/tail pointers wrapping modulo 16 and a 5-bit count.
REQ-018 SHALL drive fetch_valid = fetch_en & !redirect & (count <= 8), combinationally.
REQ-019 On fetch_valid & fetch_hit, SHALL append bytes fetch_pc[2:0]..7 of fetch_data (n = 8 - fetch_pc[2:0] bytes) at tail, then set fetch_pc = {fetch_pc[63:3]+1, 3'b000}.
REQ-020 SHALL ignore fetch_hit while fetch_valid=0.
REQ-021 On consume with consume_len in 1..out_count and <=8, SHALL advance head by consume_len and out_pc by consume_len (64-bit wrap).
REQ-022 consume_len = 0, > 8, or > out_count SHALL be ignored with no state change.
REQ-023 Simultaneous append and consume SHALL give count_next = count + n - consume_len; count never exceeds 16, guaranteed by REQ-018.
REQ-024 out_bytes byte i SHALL be queue[head+i] for i < out_count, else 0x00; combinational from registered state.
REQ-025 redirect SHALL take priority over append and consume: next cycle count=0, head=tail=0, fetch_pc=out_pc=redirect_pc; same-cycle fetch_hit is discarded.
REQ-026 Latency: a hit at cycle t SHALL make its bytes visible on out_bytes at cycle t+1.
REQ-027 fetch_en=0 SHALL not affect consume or redirect.

Reset
REQ-028 While rst=1, SHALL asynchronously set count=0, head=tail=0, fetch_pc=0, out_pc=0, stats=0; fetch_valid=0, out_count=0, out_bytes=0.
REQ-029 After rst deasserts, first fetch_valid SHALL occur in the first cycle with fetch_en=1, at fetch_addr=0.
REQ-030 Reset mid-operation SHALL discard queue contents; the I-cache refill in flight is not cancelled.

Configuration
REQ-031 With MP64_IFB_STATS_EN defined, stat_fetches SHALL increment per accepted hit and stat_stalls per stall cycle, wrapping at 2^64.
REQ-032 Without MP64_IFB_STATS_EN, stat_fetches and stat_stalls SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-033 Reset, fetch_en=1, hits with 0x0706050403020100 at addr 0 -> out_count=8, out_bytes=0x0706050403020100, out_pc=0, next fetch_addr=8.
REQ-034 redirect_pc=0x103, hit with 0x0706050403020100 -> out_count=5, out_bytes=0x0000000706050403, out_pc=0x103, next fetch_addr=0x108.
REQ-035 Two hits without consume -> count=16, fetch_valid=0; consume_len=8 -> count=8, fetch_valid=1 next cycle, out_pc advanced by 8.
REQ-036 count=6, same-cycle hit (8 bytes) and consume_len=3 -> count=11, out_pc+3.
REQ-037 redirect same cycle as fetch_hit and consume -> count=0, hit bytes absent, out_pc=redirect_pc.
REQ-038 consume_len=5 with out_count=4 -> no change; with MP64_IFB_STATS_EN, 3 miss cycles then hit -> stat_stalls=3, stat_fetches=1.
